// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a registered PC through instruction
// memory and hands words to decode through a one-entry valid/ready issue
// register. Handles halt words, resume, redirects and range faults.
module fetch_sequencer #(
  parameter int unsigned SIZE_IM  = 128,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        i_Rst,
  output logic [31:0] o_Addr,
  input  logic [31:0] i_Instruction,
  output logic [31:0] o_Instruction,
  output logic [31:0] o_PC,
  output logic        o_Valid,
  input  logic        i_Ready,
  input  logic        i_Redirect,
  input  logic [31:0] i_Target,
  input  logic        i_Resume,
  output logic        o_Halted,
  output logic        o_Fault,
  output logic [15:0] o_IssueCount
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_RUN     = 2'd1;
  localparam logic [1:0]  S_HALT    = 2'd2;
  localparam logic [1:0]  S_FAULT   = 2'd3;
  localparam logic [31:0] LIMIT     = 32'(SIZE_IM) << 2;
  localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFC;
  localparam logic [31:0] RST_INSTR = 32'hFC00_0000;
  localparam logic [5:0]  HALT_OP   = 6'b111111;

  logic [1:0]  r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt, w_pc_inc;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_opc, w_opc_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_halted, r_fault;
  logic [15:0] r_count;
  logic        w_xfer, w_redir, w_tgt_bad, w_in_range, w_load, w_is_halt, w_cnt_inc;

  assign o_Addr        = (r_state == S_RUN) ? r_pc : IDLE_ADDR;
  assign o_Instruction = r_instr;
  assign o_PC          = r_opc;
  assign o_Valid       = r_valid;
  assign o_Halted      = r_halted;
  assign o_Fault       = r_fault;
  assign o_IssueCount  = r_count;

  // Handshake and fetch qualifiers shared by the next-state logic.
  always_comb begin
    w_xfer     = r_valid & i_Ready;
    w_redir    = i_Redirect & ((r_state == S_RUN) | (r_state == S_HALT));
    w_tgt_bad  = (i_Target[1:0] != 2'b00) | (i_Target >= LIMIT);
    w_pc_inc   = r_pc + 32'd4;
    // PC sits at LIMIT after the last word is loaded; no further fetch.
    w_in_range = r_pc < LIMIT;
    w_load     = (r_state == S_RUN) & (~r_valid | i_Ready) & ~i_Redirect & w_in_range;
    w_is_halt  = i_Instruction[31:26] == HALT_OP;
    // A redirect discards the held word, so it never counts as issued.
    w_cnt_inc  = w_xfer & ~w_redir & (r_count != 16'hFFFF);
  end

  // Next state for the FSM, PC and issue register; redirect wins over all.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_instr_nxt = r_instr;
    w_opc_nxt   = r_opc;
    if (w_redir) begin
      w_valid_nxt = 1'b0;
      w_pc_nxt    = i_Target;
      w_state_nxt = w_tgt_bad ? S_FAULT : S_RUN;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = RESET_PC;
        end
        S_RUN: begin
          if (w_load) begin
            if (w_is_halt) begin
              // Halt word is not issued; PC stays on it for resume.
              w_valid_nxt = 1'b0;
              w_state_nxt = S_HALT;
            end else begin
              w_instr_nxt = i_Instruction;
              w_opc_nxt   = r_pc;
              w_valid_nxt = 1'b1;
              w_pc_nxt    = w_pc_inc;
            end
          end else if (!w_in_range && (!r_valid || i_Ready)) begin
            // Last in-range word has drained: stop for good.
            w_valid_nxt = 1'b0;
            w_state_nxt = S_FAULT;
          end else if (w_xfer) begin
            w_valid_nxt = 1'b0;
          end
        end
        S_HALT: begin
          if (w_xfer) w_valid_nxt = 1'b0;
          if (i_Resume) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = (w_pc_inc >= LIMIT) ? S_FAULT : S_RUN;
          end
        end
        default: w_valid_nxt = 1'b0;
      endcase
    end
  end

  // State registers; flags are registered decodes of the next state.
  always_ff @(posedge clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_instr  <= RST_INSTR;
      r_opc    <= 32'd0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
      r_count  <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_valid  <= w_valid_nxt;
      r_instr  <= w_instr_nxt;
      r_opc    <= w_opc_nxt;
      r_halted <= (w_state_nxt == S_HALT);
      r_fault  <= (w_state_nxt == S_FAULT);
      if (w_cnt_inc) r_count <= r_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes the expected issue
// stream, a negedge monitor pops and compares on every accepted transfer.
module tb_fetch_sequencer;

  localparam logic [31:0] ADD_W  = 32'h0064_1820;
  localparam logic [31:0] SUB_W  = 32'h0064_1822;
  localparam logic [31:0] OR_W   = 32'h0064_1825;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam logic [31:0] NOADDR = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } xfer_t;

  logic        clk = 1'b0;
  logic        i_Rst;
  logic [31:0] o_Addr, i_Instruction, o_Instruction, o_PC, i_Target;
  logic        o_Valid, i_Ready, i_Redirect, i_Resume, o_Halted, o_Fault;
  logic [15:0] o_IssueCount;

  logic [31:0] mem [0:127];
  xfer_t       exp_q[$];
  int          n_pass = 0;
  int          n_tot  = 0;

  fetch_sequencer #(.SIZE_IM(128), .RESET_PC(32'h0)) dut (
    .clk(clk), .i_Rst(i_Rst), .o_Addr(o_Addr), .i_Instruction(i_Instruction),
    .o_Instruction(o_Instruction), .o_PC(o_PC), .o_Valid(o_Valid),
    .i_Ready(i_Ready), .i_Redirect(i_Redirect), .i_Target(i_Target),
    .i_Resume(i_Resume), .o_Halted(o_Halted), .o_Fault(o_Fault),
    .o_IssueCount(o_IssueCount)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory.
  assign i_Instruction = (o_Addr < 32'd512) ? mem[o_Addr[8:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    xfer_t e;
    e.pc  = pc;
    e.ins = ins;
    exp_q.push_back(e);
  endtask

  // Assert reset, check every output asynchronously, release after one edge.
  task automatic do_reset();
    i_Rst = 1'b0;
    i_Redirect = 1'b0;
    i_Resume = 1'b0;
    #1;
    chk("rst_valid", 32'(o_Valid), 32'd0);
    chk("rst_instr", o_Instruction, 32'hFC00_0000);
    chk("rst_pc", o_PC, 32'd0);
    chk("rst_halted", 32'(o_Halted), 32'd0);
    chk("rst_fault", 32'(o_Fault), 32'd0);
    chk("rst_count", 32'(o_IssueCount), 32'd0);
    chk("rst_addr", o_Addr, NOADDR);
    i_Ready = 1'b1;
    tick();
    i_Rst = 1'b1;
  endtask

  task automatic bad_redirect(input logic [31:0] tgt);
    do_reset();
    tick();
    i_Redirect = 1'b1;
    i_Target = tgt;
    tick();
    i_Redirect = 1'b0;
    chk("bad_tgt_fault", 32'(o_Fault), 32'd1);
    chk("bad_tgt_valid", 32'(o_Valid), 32'd0);
    i_Resume = 1'b1;
    i_Redirect = 1'b1;
    i_Target = 32'h0;
    repeat (2) tick();
    i_Resume = 1'b0;
    i_Redirect = 1'b0;
    chk("bad_tgt_sticky", 32'(o_Fault), 32'd1);
    chk("bad_tgt_count", 32'(o_IssueCount), 32'd0);
  endtask

  // Monitor: every accepted transfer must match the head of the queue.
  always @(negedge clk) begin
    if (i_Rst && o_Valid && i_Ready && !i_Redirect) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL xfer_unexpected: got pc %h, required no transfer", o_PC);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        chk("xfer_pc", o_PC, e.pc);
        chk("xfer_instr", o_Instruction, e.ins);
      end
    end
  end

  initial begin
    i_Rst = 1'b1; i_Ready = 1'b1; i_Redirect = 1'b0; i_Target = 32'h0; i_Resume = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h2000_0000 | 32'(i);
    mem[0] = ADD_W; mem[1] = SUB_W; mem[2] = OR_W; mem[3] = HALT_W;
    #2;

    // Straight run into the halt word at 12.
    do_reset();
    push(32'h0, ADD_W); push(32'h4, SUB_W); push(32'h8, OR_W);
    tick();
    chk("idle_no_valid", 32'(o_Valid), 32'd0);
    chk("run_addr", o_Addr, 32'h0);
    tick();
    chk("first_valid", 32'(o_Valid), 32'd1);
    chk("first_pc", o_PC, 32'h0);
    repeat (3) tick();
    chk("halt_flag", 32'(o_Halted), 32'd1);
    chk("halt_addr", o_Addr, NOADDR);
    chk("halt_count", 32'(o_IssueCount), 32'd3);
    chk("halt_valid", 32'(o_Valid), 32'd0);
    chk("halt_q_empty", 32'(exp_q.size()), 32'd0);

    // Redirect out of HALT to 4, then stall decode for three cycles.
    i_Redirect = 1'b1; i_Target = 32'h4;
    push(32'h4, SUB_W); push(32'h8, OR_W);
    tick();
    i_Redirect = 1'b0;
    chk("redir_unhalt", 32'(o_Halted), 32'd0);
    chk("redir_addr", o_Addr, 32'h4);
    tick();
    i_Ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_pc", o_PC, 32'h4);
      chk("stall_instr", o_Instruction, SUB_W);
      chk("stall_fetch_addr", o_Addr, 32'h8);
      chk("stall_count", 32'(o_IssueCount), 32'd3);
    end
    i_Ready = 1'b1;
    repeat (2) tick();
    chk("rehalt_flag", 32'(o_Halted), 32'd1);
    chk("rehalt_count", 32'(o_IssueCount), 32'd5);

    // Resume from halt at 12 -> fetch at 16; flush redirect to 0x40 while ready.
    i_Resume = 1'b1;
    push(32'h10, mem[4]);
    tick();
    i_Resume = 1'b0;
    chk("resume_unhalt", 32'(o_Halted), 32'd0);
    chk("resume_addr", o_Addr, 32'h10);
    repeat (2) tick();
    chk("flush_word_pc", o_PC, 32'h14);
    i_Redirect = 1'b1; i_Target = 32'h40;
    for (int i = 16; i < 128; i++) push(32'(i) << 2, mem[i]);
    tick();
    i_Redirect = 1'b0;
    i_Resume = 1'b1;
    chk("flush_valid", 32'(o_Valid), 32'd0);
    chk("flush_count", 32'(o_IssueCount), 32'd6);
    chk("flush_addr", o_Addr, 32'h40);
    tick();
    i_Resume = 1'b0;
    for (int i = 0; i < 200 && o_Fault !== 1'b1; i++) tick();
    chk("end_fault", 32'(o_Fault), 32'd1);
    chk("end_last_pc", o_PC, 32'h1FC);
    chk("end_count", 32'(o_IssueCount), 32'd118);
    chk("end_valid", 32'(o_Valid), 32'd0);
    chk("end_addr", o_Addr, NOADDR);
    chk("end_q_empty", 32'(exp_q.size()), 32'd0);
    i_Redirect = 1'b1; i_Target = 32'h0; i_Resume = 1'b1;
    repeat (2) tick();
    i_Redirect = 1'b0; i_Resume = 1'b0;
    chk("fault_sticky", 32'(o_Fault), 32'd1);
    chk("fault_no_valid", 32'(o_Valid), 32'd0);

    // Misaligned and out-of-range redirect targets.
    bad_redirect(32'h42);
    bad_redirect(32'h200);

    // Redirect to the last legal word: issued once, then fault.
    do_reset();
    tick();
    i_Redirect = 1'b1; i_Target = 32'h1FC;
    push(32'h1FC, mem[127]);
    tick();
    i_Redirect = 1'b0;
    chk("edge_tgt_no_fault", 32'(o_Fault), 32'd0);
    for (int i = 0; i < 20 && o_Fault !== 1'b1; i++) tick();
    chk("edge_tgt_fault", 32'(o_Fault), 32'd1);
    chk("edge_tgt_count", 32'(o_IssueCount), 32'd1);
    chk("edge_tgt_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-cycle while a word is held.
    do_reset();
    repeat (2) tick();
    chk("pre_rst_valid", 32'(o_Valid), 32'd1);
    i_Ready = 1'b0;
    #2;
    do_reset();
    push(32'h0, ADD_W); push(32'h4, SUB_W); push(32'h8, OR_W);
    tick();
    chk("rerun_idle", 32'(o_Valid), 32'd0);
    tick();
    chk("rerun_valid", 32'(o_Valid), 32'd1);
    chk("rerun_pc", o_PC, 32'h0);
    for (int i = 0; i < 20 && o_Halted !== 1'b1; i++) tick();
    chk("rerun_halted", 32'(o_Halted), 32'd1);
    chk("rerun_count", 32'(o_IssueCount), 32'd3);
    chk("rerun_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
